uart_tx_arbiter: RTL and testbench

//   Shares the single UART core transmit port (write_uart/write_data) between NREQ byte producers.

---
 rtl/uart_tx_arbiter.sv | 115 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that shares one UART transmit push port
// between NREQ byte producers. A grant is held for one packet, so bytes from
// different producers never interleave on the line.
//
// state | meaning
// IDLE  | no owner; pick the next requester after ptr, grant it next cycle
// GRANT | grant_id owns the port until last byte, burst limit or timeout
module uart_tx_arbiter #(
  parameter int NREQ      = 4,
  parameter int DBITS     = 8,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic                      clk_100MHz,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*DBITS-1:0]     req_data,
  input  logic [NREQ-1:0]           req_last,
  output logic [NREQ-1:0]           req_ready,
  input  logic                      tx_full,
  output logic                      write_uart,
  output logic [DBITS-1:0]          write_data,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy
);

  localparam int GW = $clog2(NREQ);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic [GW-1:0]    ptr;
  logic [GW-1:0]    winner;
  logic [GW-1:0]    idx;
  logic             any_req;
  logic [7:0]       byte_cnt;
  logic [7:0]       to_cnt;
  logic             g_valid;
  logic             g_last;
  logic [DBITS-1:0] g_data;
  logic             hs;
  logic             burst_done;
  logic             timed_out;

  // Round-robin search: the lowest offset from ptr+1 wins, so scan offsets downward
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = GW'((int'(ptr) + k) % NREQ);
      if (req_valid[idx]) begin
        winner  = idx;
        any_req = 1'b1;
      end
    end
  end

  assign g_valid    = req_valid[grant_id];
  assign g_last     = req_last[grant_id];
  assign g_data     = req_data[grant_id*DBITS +: DBITS];
  assign hs         = (state == GRANT) && g_valid && !tx_full;
  assign burst_done = (byte_cnt == 8'(MAX_BURST - 1));
  assign timed_out  = !g_valid && (to_cnt == 8'(TIMEOUT - 1));
  assign busy       = (state == GRANT);

  // Only the owner sees ready, and only when the core FIFO has room
  always_comb begin
    req_ready = '0;
    if (state == GRANT && !tx_full) req_ready[grant_id] = req_valid[grant_id];
  end

  // Grant FSM with registered push strobe, burst and idle-timeout counters
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      write_uart <= 1'b0;
      write_data <= '0;
      grant_id   <= '0;
      ptr        <= GW'(NREQ - 1);
      byte_cnt   <= '0;
      to_cnt     <= '0;
    end else begin
      write_uart <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_id <= winner;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (hs) begin
            write_uart <= 1'b1;
            write_data <= g_data;
          end
          // The releasing handshake still pushes its byte above
          if ((hs && (g_last || burst_done)) || timed_out) begin
            state    <= IDLE;
            ptr      <= grant_id;
            byte_cnt <= '0;
            to_cnt   <= '0;
          end else if (hs) begin
            byte_cnt <= byte_cnt + 8'd1;
            to_cnt   <= '0;
          end else if (!g_valid) begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues drive bytes, expected
// {grant_id, byte} pairs are queued at issue time and checked by a monitor.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int DBITS = 8;

  logic                  clk_100MHz = 1'b0;
  logic                  reset = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*DBITS-1:0] req_data = '0;
  logic [NREQ-1:0]       req_last = '0;
  logic [NREQ-1:0]       req_ready;
  logic                  tx_full = 1'b0;
  logic                  write_uart;
  logic [DBITS-1:0]      write_data;
  logic [1:0]            grant_id;
  logic                  busy;

  uart_tx_arbiter #(.NREQ(NREQ), .DBITS(DBITS), .MAX_BURST(16), .TIMEOUT(64)) dut (
    .clk_100MHz(clk_100MHz),
    .reset(reset),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .tx_full(tx_full),
    .write_uart(write_uart),
    .write_data(write_data),
    .grant_id(grant_id),
    .busy(busy)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [8:0]  rq [NREQ][$];   // {last, data} per requester
  logic [9:0]  sb [$];         // expected {grant_id, data}
  int          wr_cyc [$];
  logic        wr_busy [$];

  initial forever begin
    @(posedge clk_100MHz);
    cyc++;
  end

  // Requester model: present queue head, pop it when accepted
  initial begin
    logic [NREQ-1:0] acc;
    forever begin
      @(negedge clk_100MHz);
      for (int i = 0; i < NREQ; i++) begin
        if (rq[i].size() > 0) begin
          req_valid[i]            = 1'b1;
          req_data[i*DBITS +: DBITS] = rq[i][0][7:0];
          req_last[i]             = rq[i][0][8];
        end else begin
          req_valid[i]            = 1'b0;
          req_data[i*DBITS +: DBITS] = '0;
          req_last[i]             = 1'b0;
        end
      end
      #3;
      acc = req_ready;
      @(posedge clk_100MHz);
      for (int i = 0; i < NREQ; i++)
        if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    end
  end

  // Monitor: every push to the core is compared against the scoreboard head
  initial begin
    logic [9:0] exp_v;
    forever begin
      @(negedge clk_100MHz);
      if (write_uart === 1'b1) begin
        wr_cyc.push_back(cyc);
        wr_busy.push_back(busy);
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got id=%0d data=%02h want no write", grant_id, write_data);
        end else begin
          exp_v = sb.pop_front();
          if ({grant_id, write_data} !== exp_v) begin
            errors++;
            $display("FAIL sb_byte: got id=%0d data=%02h want id=%0d data=%02h",
                     grant_id, write_data, exp_v[9:8], exp_v[7:0]);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic send(input int id, input logic [7:0] d, input logic last);
    rq[id].push_back({last, d});
  endtask

  task automatic expect_b(input int id, input logic [7:0] d);
    sb.push_back({2'(id), d});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    sb.delete();
    repeat (2) @(negedge clk_100MHz);
    reset = 1'b0;
  endtask

  task automatic start_test();
    wr_cyc.delete();
    wr_busy.delete();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic wait_write(input string name);
    int n = 0;
    do begin
      @(negedge clk_100MHz);
      n++;
    end while (write_uart !== 1'b1 && n < 50);
    if (write_uart !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s: got no write_uart want one within 50 cycles", name);
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk_100MHz);
      n++;
    end
    check(name, sb.size(), 0);
  endtask

  initial begin
    logic rdy_seen;
    logic wr_seen;
    int   n;

    // Reset values
    #2;
    check("rst_write_uart", write_uart, 0);
    check("rst_write_data", write_data, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 0);
    do_reset();

    // 1: single 3-byte packet from requester 1
    start_test();
    send(1, 8'h41, 0); send(1, 8'h42, 0); send(1, 8'h43, 1);
    expect_b(1, 8'h41); expect_b(1, 8'h42); expect_b(1, 8'h43);
    @(negedge clk_100MHz);
    check("t1_ready_in_idle", req_ready, 0);
    @(negedge clk_100MHz);
    check("t1_grant_id", grant_id, 1);
    check("t1_busy", busy, 1);
    drain("t1_drain", 40);
    check("t1_nwrites", wr_cyc.size(), 3);
    check("t1_gap01", wr_cyc[1] - wr_cyc[0], 1);
    check("t1_gap12", wr_cyc[2] - wr_cyc[1], 1);
    check("t1_busy_2nd", wr_busy[1], 1);
    check("t1_busy_3rd", wr_busy[2], 0);

    // 2: requesters 0 and 2 contend from reset; 0 goes first, no interleave
    do_reset();
    start_test();
    send(0, 8'hA0, 0); send(0, 8'hA1, 1);
    send(2, 8'hB0, 0); send(2, 8'hB1, 1);
    expect_b(0, 8'hA0); expect_b(0, 8'hA1); expect_b(2, 8'hB0); expect_b(2, 8'hB1);
    drain("t2_drain", 40);
    check("t2_gap01", wr_cyc[1] - wr_cyc[0], 1);
    check("t2_gap12", wr_cyc[2] - wr_cyc[1], 2);
    check("t2_gap23", wr_cyc[3] - wr_cyc[2], 1);

    // 3: 20-byte stream without last, forced release after 16 bytes
    do_reset();
    start_test();
    for (int k = 0; k < 20; k++) send(3, 8'(8'h60 + k), 0);
    for (int k = 0; k < 16; k++) expect_b(3, 8'(8'h60 + k));
    expect_b(0, 8'h90);
    for (int k = 16; k < 20; k++) expect_b(3, 8'(8'h60 + k));
    n = 0;
    do begin
      @(negedge clk_100MHz);
      n++;
    end while (busy !== 1'b1 && n < 20);
    check("t3_granted", busy, 1);
    @(posedge clk_100MHz);
    #1;
    send(0, 8'h90, 1);
    drain("t3_drain", 100);
    check("t3_release_gap", wr_cyc[16] - wr_cyc[15], 2);
    check("t3_resume_gap", wr_cyc[17] - wr_cyc[16], 2);

    // 4: owner drops valid after one byte, timeout hands over to waiting req2
    do_reset();
    start_test();
    send(1, 8'h11, 0);
    send(2, 8'h22, 1);
    expect_b(1, 8'h11); expect_b(2, 8'h22);
    wait_write("t4_first_write");
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk_100MHz);
    end
    check("t4_timeout_cycles", n, 64);
    drain("t4_drain", 20);

    // 5: tx_full stalls a packet for 10 cycles without timing out
    do_reset();
    start_test();
    send(2, 8'h51, 0); send(2, 8'h52, 0); send(2, 8'h53, 0); send(2, 8'h54, 1);
    expect_b(2, 8'h51); expect_b(2, 8'h52); expect_b(2, 8'h53); expect_b(2, 8'h54);
    wait_write("t5_first_write");
    tx_full  = 1'b1;
    rdy_seen = 1'b0;
    wr_seen  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #4;
      rdy_seen |= |req_ready;
      @(negedge clk_100MHz);
      wr_seen |= write_uart;
    end
    tx_full = 1'b0;
    check("t5_ready_while_full", rdy_seen, 0);
    check("t5_write_while_full", wr_seen, 0);
    check("t5_busy_held", busy, 1);
    @(negedge clk_100MHz);
    check("t5_resume_write", write_uart, 1);
    drain("t5_drain", 20);

    // 6: reset mid-packet cancels the grant and restores requester 0 priority
    start_test();
    send(1, 8'hC1, 0); send(1, 8'hC2, 0); send(1, 8'hC3, 1);
    expect_b(1, 8'hC1);
    wait_write("t6_first_write");
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_write_uart", write_uart, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_req_ready", req_ready, 0);
    check("t6_sb_empty", sb.size(), 0);
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    repeat (2) @(negedge clk_100MHz);
    reset = 1'b0;
    start_test();
    send(3, 8'hD3, 1);
    send(0, 8'hD0, 1);
    expect_b(0, 8'hD0); expect_b(3, 8'hD3);
    @(negedge clk_100MHz);
    @(negedge clk_100MHz);
    check("t6_first_grant", grant_id, 0);
    drain("t6_drain", 40);

    repeat (3) @(negedge clk_100MHz);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
